alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the integer pipe and a branch/address unit.
- Each requester uses a valid/ready request channel. The arbiter round-robins the grant and drives the ALU operand and opcode inputs.
- The ALU output is captured in a one-entry response buffer, tagged with the requester ID.
- Sits between the requesters and the ALU; the ALU itself is external.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OPCODE_LENGTH, 4, ALU operation code width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_src_a  in  DATA_WIDTH  requester 0 operand A.
- req0_src_b  in  DATA_WIDTH  requester 0 operand B.
- req0_op  in  OPCODE_LENGTH  requester 0 ALU operation.
- req1_valid, req1_ready, req1_src_a, req1_src_b, req1_op: same as the requester 0 ports, for requester 1.
- alu_src_a  out  DATA_WIDTH  to ALU SrcA.
- alu_src_b  out  DATA_WIDTH  to ALU SrcB.
- alu_op  out  OPCODE_LENGTH  to ALU Operation.
- alu_result  in  DATA_WIDTH  from ALU ALUResult.
- alu_zero  in  1  from ALU Zero.
- resp_valid  out  1  response buffer holds a result.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester that issued the buffered result.
- resp_result  out  DATA_WIDTH  buffered ALU result.
- resp_zero  out  1  buffered Zero flag.

Behaviour:
- can_accept = !resp_valid | resp_ready.
- Grant selection (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- last_grant resets to 1, so requester 0 wins the first tie.
- reqN_ready = granted(N) & can_accept. At most one ready is high per cycle. A requester's ready never asserts while its valid is low.
- ALU drive is combinational from the granted requester, driven even when can_accept=0. With no grant, alu_src_a = alu_src_b = 0 and alu_op = 4'b0000.
- Accept event: reqN_valid & reqN_ready. On the accept cycle's clock edge:
  - Register resp_result <= alu_result, resp_zero <= alu_zero, resp_id <= N.
  - Set resp_valid <= 1 and last_grant <= N.
- Latency: accept in cycle T, so resp_valid=1 in cycle T+1. Throughput is one op per cycle when resp_ready stays high.
- Response buffer states:
  - EMPTY --accept--> FULL.
  - FULL & resp_ready & !accept --> EMPTY.
  - FULL & resp_ready & accept --> FULL with new data (simultaneous drain and fill).
  - FULL & !resp_ready --> FULL; data held stable, no accept possible.
- While resp_valid=1 and resp_ready=0: resp_result, resp_zero and resp_id must not change.
- last_grant changes only on accept; a grant that is blocked by backpressure does not rotate priority.
- Requesters must hold valid and their operands until ready. The arbiter does not check this.
- Reset (any cycle, including mid-stall):
  - resp_valid=0, resp_result=0, resp_zero=0, resp_id=0, last_grant=1.
  - An in-flight buffered result is discarded.
  - req0_ready=req1_ready=0 during the reset cycle.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- When defined: fixed priority. Requester 0 always wins when both are valid, and last_grant logic is removed.
- When undefined: round-robin as described under Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Single op: req0 valid, op=4'b0010, A=5, B=7, resp_ready=1 -> req0_ready=1 in cycle T; next cycle resp_valid=1, resp_result=12, resp_zero=0, resp_id=0.
- Tie, round-robin: both valid every cycle; req0 op=4'b0110 A=10 B=3; req1 op=4'b1000 A=4 B=4 -> grants 0,1,0,1; results 7,1,7,1 with resp_zero 1,1,1,1; resp_id alternates 0,1.
- Backpressure: resp_ready=0 after the first accept, req1 valid -> req1_ready=0 for 3 cycles, response held stable. Raise resp_ready -> drain and accept req1 in the same cycle; next response is req1's.
- Zero/compare: req1 op=4'b1100, A=32'hFFFF_FFFF, B=1 -> resp_result=1, resp_zero=1, resp_id=1.
- Reset mid-stall: buffer FULL with resp_ready=0, assert reset for one cycle -> resp_valid=0. After reset, a tie grants requester 0 first.
- ALU_ARB_FIXED_PRIO_EN defined: both valid for 4 cycles -> req0 granted all 4, req1_ready stays 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between the two requesters, the external ALU and the arbiter.
// The slave modport is the arbiter. The master modport is the requesters, the ALU and the response consumer.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic [DATA_WIDTH-1:0]    req0_src_a;
    logic [DATA_WIDTH-1:0]    req0_src_b;
    logic [OPCODE_LENGTH-1:0] req0_op;

    logic                     req1_valid;
    logic                     req1_ready;
    logic [DATA_WIDTH-1:0]    req1_src_a;
    logic [DATA_WIDTH-1:0]    req1_src_b;
    logic [OPCODE_LENGTH-1:0] req1_op;

    logic [DATA_WIDTH-1:0]    alu_src_a;
    logic [DATA_WIDTH-1:0]    alu_src_b;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic                     alu_zero;

    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_id;
    logic [DATA_WIDTH-1:0]    resp_result;
    logic                     resp_zero;

    modport slave (
        input  req0_valid, req0_src_a, req0_src_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_src_a, req1_src_b, req1_op,
        output req1_ready,
        output alu_src_a, alu_src_b, alu_op,
        input  alu_result, alu_zero,
        output resp_valid, resp_id, resp_result, resp_zero,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_src_a, req0_src_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_src_a, req1_src_b, req1_op,
        input  req1_ready,
        input  alu_src_a, alu_src_b, alu_op,
        output alu_result, alu_zero,
        input  resp_valid, resp_id, resp_result, resp_zero,
        output resp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters. Results land in a one-entry response buffer tagged with the requester ID, one cycle after accept.
// Ties are round-robin. Defining ALU_ARB_FIXED_PRIO_EN gives fixed priority instead, where requester 0 always wins.
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input logic          clk,
    input logic          reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t            state;
    buf_state_t            state_nxt;
    logic                  gnt_vld;
    logic                  gnt_id;
    logic                  can_accept;
    logic                  accept;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        gnt_id  = ~bus.req0_valid;
    end
`else
    logic last_grant;

    always_comb begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            gnt_id = ~last_grant;
        else
            gnt_id = ~bus.req0_valid;
    end

    // Priority rotates only on a real accept, never on a grant stalled by backpressure.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= gnt_id;
    end
`endif

    assign can_accept     = (state == EMPTY) | bus.resp_ready;
    assign accept         = gnt_vld & can_accept & ~reset;
    assign bus.req0_ready = accept & ~gnt_id;
    assign bus.req1_ready = accept & gnt_id;

    // The ALU sees the granted operands even while the buffer is stalled.
    always_comb begin
        bus.alu_src_a = '0;
        bus.alu_src_b = '0;
        bus.alu_op    = '0;
        if (gnt_vld) begin
            if (gnt_id) begin
                bus.alu_src_a = bus.req1_src_a;
                bus.alu_src_b = bus.req1_src_b;
                bus.alu_op    = bus.req1_op;
            end else begin
                bus.alu_src_a = bus.req0_src_a;
                bus.alu_src_b = bus.req0_src_b;
                bus.alu_op    = bus.req0_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (bus.resp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            id_q     <= 1'b0;
        end else if (accept) begin
            result_q <= bus.alu_result;
            zero_q   <= bus.alu_zero;
            id_q     <= gnt_id;
        end
    end

    assign bus.resp_valid  = (state == FULL);
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_id     = id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter, with a small ALU model standing in for the external ALU.
// The bench has a hand-written sequence for a reset that arrives while the response buffer is stalled.
module tb_alu_arbiter;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    alu_arbiter_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ALU stand-in: Zero carries the branch condition for sub/compare ops.
    always_comb begin
        bus.alu_result = 32'd0;
        bus.alu_zero   = 1'b1;
        case (bus.alu_op)
            4'h2: begin
                bus.alu_result = bus.alu_src_a + bus.alu_src_b;
                bus.alu_zero   = (bus.alu_result == 32'd0);
            end
            4'h6: begin
                bus.alu_result = bus.alu_src_a - bus.alu_src_b;
                bus.alu_zero   = (bus.alu_src_a != bus.alu_src_b);
            end
            4'h8: begin
                bus.alu_result = {31'd0, bus.alu_src_a == bus.alu_src_b};
                bus.alu_zero   = bus.alu_result[0];
            end
            4'hC: begin
                bus.alu_result = {31'd0, $signed(bus.alu_src_a) < $signed(bus.alu_src_b)};
                bus.alu_zero   = bus.alu_result[0];
            end
            default: ;
        endcase
    end

    typedef struct {
        logic        v0, v1, s0, s1, rr;
        logic        e_rdy0, e_rdy1;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        logic        e_vld;
        logic [31:0] e_res;
        logic        e_z, e_id;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic v0, v1, s0, s1, rr, r0, r1,
                                input logic [3:0] op, input logic [31:0] a, b,
                                input logic vld, input logic [31:0] res, input logic z, id);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.s0 = s0; v.s1 = s1; v.rr = rr;
        v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_op = op; v.e_a = a; v.e_b = b;
        v.e_vld = vld; v.e_res = res; v.e_z = z; v.e_id = id;
        return v;
    endfunction

    // Operand set 0: req0 sub 10-3, req1 eq 4,4. Operand set 1: req0 add 5+7, req1 slt -1,1.
    task automatic drive(input logic v0, v1, s0, s1, rr);
        bus.req0_valid = v0;
        bus.req0_op    = s0 ? 4'h2  : 4'h6;
        bus.req0_src_a = s0 ? 32'd5 : 32'd10;
        bus.req0_src_b = s0 ? 32'd7 : 32'd3;
        bus.req1_valid = v1;
        bus.req1_op    = s1 ? 4'hC : 4'h8;
        bus.req1_src_a = s1 ? 32'hFFFF_FFFF : 32'd4;
        bus.req1_src_b = s1 ? 32'd1 : 32'd4;
        bus.resp_ready = rr;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = mk(H,H,L,L,H, H,L,4'h6,32'd10,32'd3, L,32'd0,L,L);
        tbl[1]  = mk(H,H,L,L,H, L,H,4'h8,32'd4,32'd4, H,32'd7,H,L);
        tbl[2]  = mk(H,H,L,L,H, H,L,4'h6,32'd10,32'd3, H,32'd1,H,H);
        tbl[3]  = mk(H,H,L,L,H, L,H,4'h8,32'd4,32'd4, H,32'd7,H,L);
        tbl[4]  = mk(L,L,L,L,H, L,L,4'h0,32'd0,32'd0, H,32'd1,H,H);
        tbl[5]  = mk(H,L,H,L,H, H,L,4'h2,32'd5,32'd7, L,32'd0,L,L);
        tbl[6]  = mk(L,H,L,H,L, L,L,4'hC,32'hFFFF_FFFF,32'd1, H,32'd12,L,L);
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = mk(L,H,L,H,H, L,H,4'hC,32'hFFFF_FFFF,32'd1, H,32'd12,L,L);
        tbl[10] = mk(H,L,H,L,H, H,L,4'h2,32'd5,32'd7, H,32'd1,H,H);
        tbl[11] = mk(L,L,L,L,L, L,L,4'h0,32'd0,32'd0, H,32'd12,L,L);
`ifdef ALU_ARB_FIXED_PRIO_EN
        tbl[1]  = mk(H,H,L,L,H, H,L,4'h6,32'd10,32'd3, H,32'd7,H,L);
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(L,L,L,L,H, L,L,4'h0,32'd0,32'd0, H,32'd7,H,L);
`endif

        reset = 1'b1;
        drive(H, H, L, L, L);
        @(negedge clk);
        chk("rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_vld",  {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].s0, tbl[i].s1, tbl[i].rr);
            @(negedge clk);
            chk($sformatf("row%0d_rdy0", i), {31'd0, bus.req0_ready}, {31'd0, tbl[i].e_rdy0});
            chk($sformatf("row%0d_rdy1", i), {31'd0, bus.req1_ready}, {31'd0, tbl[i].e_rdy1});
            chk($sformatf("row%0d_op", i),   {28'd0, bus.alu_op},     {28'd0, tbl[i].e_op});
            chk($sformatf("row%0d_a", i),    bus.alu_src_a,           tbl[i].e_a);
            chk($sformatf("row%0d_b", i),    bus.alu_src_b,           tbl[i].e_b);
            chk($sformatf("row%0d_vld", i),  {31'd0, bus.resp_valid}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("row%0d_res", i),  bus.resp_result,        tbl[i].e_res);
                chk($sformatf("row%0d_zero", i), {31'd0, bus.resp_zero}, {31'd0, tbl[i].e_z});
                chk($sformatf("row%0d_id", i),   {31'd0, bus.resp_id},   {31'd0, tbl[i].e_id});
            end
            @(posedge clk);
            #1;
        end

        // Buffer is FULL, stalled, and last_grant is 0. A one-cycle reset must clear all of it.
        reset = 1'b1;
        drive(H, H, L, L, L);
        @(negedge clk);
        chk("midrst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        chk("midrst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(H, H, L, L, H);
        @(negedge clk);
        chk("postrst_vld",  {31'd0, bus.resp_valid}, 32'd0);
        chk("postrst_res",  bus.resp_result,         32'd0);
        chk("postrst_zero", {31'd0, bus.resp_zero},  32'd0);
        chk("postrst_id",   {31'd0, bus.resp_id},    32'd0);
        chk("postrst_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        chk("postrst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1 drive(L, L, L, L, H);
        @(negedge clk);
        chk("postrst_resp_vld", {31'd0, bus.resp_valid}, 32'd1);
        chk("postrst_resp_res", bus.resp_result,         32'd7);
        chk("postrst_resp_id",  {31'd0, bus.resp_id},    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
